// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants and state encoding for the nibble-serial adder
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_nibble_adder.sv
// rtl/nibble_serial_adder_nibble_adder.sv - combinational 4-bit ripple-carry adder of full-adder cells
module nibble_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_cell
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle wide adder stepping one nibble adder LSB-first per cycle
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [NIBBLE_W-1:0] nib_sum;
    logic               nib_carry;

    nibble_adder u_nibble_adder (
        .a     (a_reg[idx*NIBBLE_W +: NIBBLE_W]),
        .b     (b_reg[idx*NIBBLE_W +: NIBBLE_W]),
        .c_in  (carry),
        .sum   (nib_sum),
        .c_out (nib_carry)
    );

    // Handshake flags come straight from the state register so no input reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)          next_state = RUN;
            RUN:     if (idx == LAST_IDX)   next_state = DONE;
            DONE:    if (out_ready)         next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry                         <= nib_carry;
                    if (idx == LAST_IDX) begin
                        cout <= nib_carry;
                        // Carry into the MSB is recovered as a^b^sum at that bit.
                        ovf  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ nib_sum[NIBBLE_W-1] ^ nib_carry;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
